// File: rtl/pipe_ctrl_pkg.sv
// Package for the pipeline control sequencer.
// Holds the FSM state codes, the itype encodings, the PC-mux and writeback-mux
// select values, the decoded instr codes of interest and a small decode helper.
package pipe_ctrl_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_MULW  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  // itype_ex encodings
  localparam logic [2:0] IT_R = 3'b000;  // R-type and CSR
  localparam logic [2:0] IT_I = 3'b001;  // I-type and jalr
  localparam logic [2:0] IT_U = 3'b010;  // lui
  localparam logic [2:0] IT_B = 3'b011;  // branches
  localparam logic [2:0] IT_J = 3'b100;  // jal

  // PC mux selects
  localparam logic [1:0] PC_SEL_PC4  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_JAL  = 2'b10;
  localparam logic [1:0] PC_SEL_JALR = 2'b11;

  // Writeback mux selects
  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_PC4  = 2'b01;
  localparam logic [1:0] WB_SEL_UIMM = 2'b10;
  localparam logic [1:0] WB_SEL_EXT  = 2'b11;  // multiplier or CSR result

  // Decoded instr codes (valid when itype is IT_R)
  localparam logic [3:0] INSTR_MUL   = 4'b0101;
  localparam logic [3:0] INSTR_MULH  = 4'b0110;
  localparam logic [3:0] INSTR_MULHU = 4'b0111;
  localparam logic [3:0] INSTR_CSRRW = 4'b1101;

  // Raw opcodes
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_CSRRW = 7'b1110011;

  function automatic logic is_mul(input logic [3:0] instr);
    return (instr == INSTR_MUL) || (instr == INSTR_MULH) || (instr == INSTR_MULHU);
  endfunction

endpackage

// File: rtl/pipe_ctrl_fsm_if.sv
// Bundle between the EX stage / datapath and the control sequencer.
// Handshake: the multiplier raises mul_ready for one cycle when its result is
// valid; the sequencer only samples it while waiting on a multiply it started
// with the one-cycle mul_start pulse. All other signals are level controls.
//   slave  : the sequencer (consumes EX fields, drives controls)
//   master : the datapath side (drives EX fields, consumes controls)
interface pipe_ctrl_fsm_if;
  logic        valid_ex;
  logic [2:0]  itype_ex;
  logic [3:0]  instr_ex;
  logic [6:0]  opcode_ex;
  logic [2:0]  funct3_ex;
  logic [4:0]  rd_ex;
  logic        alu_zero;
  logic        alu_lt;
  logic        mul_ready;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        fetch_flush;
  logic        mul_start;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        alu_b_sel;
  logic        csr_we;
  logic        illegal;
  logic        mul_abort;
  logic [31:0] instret;

  modport slave (
    input  valid_ex, itype_ex, instr_ex, opcode_ex, funct3_ex, rd_ex,
           alu_zero, alu_lt, mul_ready,
    output pc_en, pc_sel, fetch_flush, mul_start, rf_we, wb_sel,
           alu_b_sel, csr_we, illegal, mul_abort, instret
  );

  modport master (
    output valid_ex, itype_ex, instr_ex, opcode_ex, funct3_ex, rd_ex,
           alu_zero, alu_lt, mul_ready,
    input  pc_en, pc_sel, fetch_flush, mul_start, rf_we, wb_sel,
           alu_b_sel, csr_we, illegal, mul_abort, instret
  );
endinterface

// File: rtl/pipe_ctrl_fsm_branch_eval.sv
// Branch condition evaluator (combinational).
// Ports: funct3 (branch condition), alu_zero, alu_lt -> taken, bad_funct3.
// beq uses alu_zero; blt/bltu use alu_lt; bge/bgeu use !alu_lt.
// funct3 001/010/011 are not supported and flag bad_funct3.
module branch_eval (
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_lt,
  output logic       taken,
  output logic       bad_funct3
);
  always_comb begin
    taken      = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      3'b000:         taken = alu_zero;
      3'b100, 3'b110: taken = alu_lt;
      3'b101, 3'b111: taken = ~alu_lt;
      default:        bad_funct3 = 1'b1;
    endcase
  end
endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Control sequencer for the 3-stage RV32 core.
// Ports: clk, rst (synchronous, active-high), bus (slave side of
// pipe_ctrl_fsm_if: EX-stage fields in, datapath controls out), fsm_state
// (current FSM state, observation only).
// All controls are combinational from state and EX inputs; state, timers,
// instret and mul_abort are registered.
module pipe_ctrl_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  pipe_ctrl_fsm_if.slave   bus,
  output logic [1:0]       fsm_state
);
  localparam int TW = $clog2(MUL_TIMEOUT + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(MUL_TIMEOUT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  logic [1:0]    state_q, state_n;
  logic [TW-1:0] timer_q;
  logic [FW-1:0] flush_q;
  logic [31:0]   instret_q;
  logic          abort_q;
  logic          retire, abort_set;
  logic          br_taken, br_bad;
  logic          rd_nz;

  assign rd_nz     = |bus.rd_ex;
  assign fsm_state = state_q;

  branch_eval u_branch_eval (
    .funct3     (bus.funct3_ex),
    .alu_zero   (bus.alu_zero),
    .alu_lt     (bus.alu_lt),
    .taken      (br_taken),
    .bad_funct3 (br_bad)
  );

  // Registered outputs read as zero while reset is held.
  assign bus.mul_abort = abort_q & ~rst;
  assign bus.instret   = rst ? 32'd0 : instret_q;

  always_comb begin
    bus.pc_en       = 1'b0;
    bus.pc_sel      = PC_SEL_PC4;
    bus.fetch_flush = 1'b0;
    bus.mul_start   = 1'b0;
    bus.rf_we       = 1'b0;
    bus.wb_sel      = WB_SEL_ALU;
    bus.alu_b_sel   = 1'b0;
    bus.csr_we      = 1'b0;
    bus.illegal     = 1'b0;
    state_n         = state_q;
    retire          = 1'b0;
    abort_set       = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: state_n = ST_RUN;
        ST_RUN: begin
          bus.pc_en = 1'b1;
          if (bus.valid_ex) begin
            case (bus.itype_ex)
              IT_R: begin
                if (is_mul(bus.instr_ex)) begin
                  // Hold the PC until the multiplier answers or times out.
                  bus.mul_start = 1'b1;
                  bus.pc_en     = 1'b0;
                  state_n       = ST_MULW;
                end else begin
                  bus.rf_we = rd_nz;
                  retire    = 1'b1;
                  if (bus.instr_ex == INSTR_CSRRW) begin
                    bus.wb_sel = WB_SEL_EXT;
                    bus.csr_we = 1'b1;
                  end
                end
              end
              IT_I: begin
                bus.alu_b_sel = 1'b1;
                bus.rf_we     = rd_nz;
                retire        = 1'b1;
                if (bus.opcode_ex == OPC_JALR) begin
                  bus.pc_sel      = PC_SEL_JALR;
                  bus.wb_sel      = WB_SEL_PC4;
                  bus.fetch_flush = 1'b1;
                  state_n         = ST_FLUSH;
                end
              end
              IT_U: begin
                bus.rf_we  = rd_nz;
                bus.wb_sel = WB_SEL_UIMM;
                retire     = 1'b1;
              end
              IT_B: begin
                if (br_bad) begin
                  bus.illegal = 1'b1;
                end else begin
                  retire = 1'b1;
                  if (br_taken) begin
                    bus.pc_sel      = PC_SEL_BR;
                    bus.fetch_flush = 1'b1;
                    state_n         = ST_FLUSH;
                  end
                end
              end
              IT_J: begin
                bus.pc_sel      = PC_SEL_JAL;
                bus.rf_we       = rd_nz;
                bus.wb_sel      = WB_SEL_PC4;
                bus.fetch_flush = 1'b1;
                retire          = 1'b1;
                state_n         = ST_FLUSH;
              end
              default: bus.illegal = 1'b1;
            endcase
          end
        end
        ST_MULW: begin
          if (bus.mul_ready) begin
            bus.pc_en  = 1'b1;
            bus.rf_we  = rd_nz;
            bus.wb_sel = WB_SEL_EXT;
            retire     = 1'b1;
            state_n    = ST_RUN;
          end else if (timer_q == TIMER_LAST) begin
            // Give up on this multiply: skip it without writing or retiring.
            bus.pc_en = 1'b1;
            abort_set = 1'b1;
            state_n   = ST_RUN;
          end
        end
        ST_FLUSH: begin
          bus.pc_en = 1'b1;
          if (flush_q == FLUSH_LAST) state_n = ST_RUN;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      flush_q   <= '0;
      instret_q <= 32'd0;
      abort_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      // Counters run only while in their state, so each entry starts at 0.
      timer_q <= (state_q == ST_MULW)  ? timer_q + TW'(1) : '0;
      flush_q <= (state_q == ST_FLUSH) ? flush_q + FW'(1) : '0;
      if (retire)    instret_q <= instret_q + 32'd1;
      if (abort_set) abort_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
module tb_pipe_ctrl_fsm;
  localparam int MUL_TIMEOUT  = 16;
  localparam int FLUSH_CYCLES = 1;

  // Reference model phases (instruction-level view of the sequencer)
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_MUL  = 2;
  localparam int P_BUB  = 3;

  logic       clk = 1'b1;
  logic       rst;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_fsm_if bus_if ();

  pipe_ctrl_fsm #(
    .MUL_TIMEOUT  (MUL_TIMEOUT),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .fsm_state (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Observed bundle: {instret, pc_en, pc_sel, fetch_flush, mul_start, rf_we,
  //                   wb_sel, alu_b_sel, csr_we, illegal, mul_abort}
  logic [43:0] obs;
  assign obs = {bus_if.instret, bus_if.pc_en, bus_if.pc_sel, bus_if.fetch_flush,
                bus_if.mul_start, bus_if.rf_we, bus_if.wb_sel, bus_if.alu_b_sel,
                bus_if.csr_we, bus_if.illegal, bus_if.mul_abort};

  // ---------------- reference model ----------------
  int          m_phase = P_IDLE, m_wait = 0, m_bub = 0;
  logic [31:0] m_instret = 32'd0;
  logic        m_abort = 1'b0;
  int          n_phase, n_wait, n_bub;
  logic [31:0] n_instret;
  logic        n_abort;
  logic [43:0] exp_q[$];

  // Predicts this cycle's outputs from the current inputs and pushes them.
  task automatic model_eval;
    logic pe, ff, ms, rw, abs, cw, il, ab, taken, retire;
    logic [1:0] ps, ws;
    logic [31:0] ei;
    logic [2:0] it, f3;
    logic [3:0] ins;
    pe = 0; ff = 0; ms = 0; rw = 0; abs = 0; cw = 0; il = 0; ps = 0; ws = 0;
    retire = 0;
    n_phase = m_phase; n_wait = m_wait; n_bub = m_bub;
    n_instret = m_instret; n_abort = m_abort;
    it = bus_if.itype_ex; f3 = bus_if.funct3_ex; ins = bus_if.instr_ex;
    if (rst) begin
      n_phase = P_IDLE; n_wait = 0; n_bub = 0; n_instret = 0; n_abort = 0;
      ei = 0; ab = 0;
    end else begin
      ei = m_instret; ab = m_abort;
      case (m_phase)
        P_IDLE: n_phase = P_RUN;
        P_BUB: begin
          pe = 1;
          n_bub = m_bub + 1;
          if (n_bub >= FLUSH_CYCLES) begin n_phase = P_RUN; n_bub = 0; end
        end
        P_MUL: begin
          n_wait = m_wait + 1;
          if (bus_if.mul_ready) begin
            pe = 1; rw = (bus_if.rd_ex != 0); ws = 3; retire = 1;
            n_phase = P_RUN; n_wait = 0;
          end else if (n_wait == MUL_TIMEOUT) begin
            pe = 1; n_abort = 1; n_phase = P_RUN; n_wait = 0;
          end
        end
        default: begin
          pe = 1;
          if (bus_if.valid_ex) begin
            if (it > 4 || (it == 3 && f3 inside {3'd1, 3'd2, 3'd3})) begin
              il = 1;
            end else if (it == 0 && ins inside {4'd5, 4'd6, 4'd7}) begin
              ms = 1; pe = 0; n_phase = P_MUL; n_wait = 0;
            end else if (it == 4 || (it == 1 && bus_if.opcode_ex == 7'h67)) begin
              ps = (it == 4) ? 2'd2 : 2'd3; abs = (it == 1);
              rw = (bus_if.rd_ex != 0); ws = 1; ff = 1; retire = 1;
              n_phase = P_BUB; n_bub = 0;
            end else if (it == 3) begin
              if (f3 == 0) taken = bus_if.alu_zero;
              else if (f3 == 4 || f3 == 6) taken = bus_if.alu_lt;
              else taken = !bus_if.alu_lt;
              retire = 1;
              if (taken) begin ps = 1; ff = 1; n_phase = P_BUB; n_bub = 0; end
            end else begin
              rw = (bus_if.rd_ex != 0); retire = 1; abs = (it == 1);
              cw = (it == 0 && ins == 13);
              ws = (it == 2) ? 2'd2 : (cw ? 2'd3 : 2'd0);
            end
          end
        end
      endcase
      if (retire) n_instret = m_instret + 32'd1;
    end
    exp_q.push_back({ei, pe, ps, ff, ms, rw, ws, abs, cw, il, ab});
  endtask

  task automatic model_commit;
    m_phase = n_phase; m_wait = n_wait; m_bub = n_bub;
    m_instret = n_instret; m_abort = n_abort;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [2:0] it, input logic [3:0] ins,
                       input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic z, input logic lt, input logic rdy);
    bus_if.valid_ex  = v;
    bus_if.itype_ex  = it;
    bus_if.instr_ex  = ins;
    bus_if.opcode_ex = opc;
    bus_if.funct3_ex = f3;
    bus_if.rd_ex     = rd;
    bus_if.alu_zero  = z;
    bus_if.alu_lt    = lt;
    bus_if.mul_ready = rdy;
  endtask

  task automatic advance;
    @(posedge clk);
    model_commit;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [43:0] e;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) rst = 1'b0;
      drive(1'b0, 3'd0, 4'd0, 7'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); model_eval; e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL reset c%0d obs=%h exp=%h st=%0d", c, obs, e, fsm_state);
      end
      checks++;
      if (c == 2 && bus_if.pc_en !== 1'b0) begin
        errors++; $display("FAIL reset_idle_pc_en got %b want 0", bus_if.pc_en);
      end else if (c == 3 && bus_if.pc_en !== 1'b1) begin
        errors++; $display("FAIL reset_run_pc_en got %b want 1", bus_if.pc_en);
      end
      advance;
    end
  endtask

  task automatic test_addi;
    logic [43:0] e;
    logic [4:0] rds [3] = '{5'd5, 5'd0, 5'd17};
    logic [31:0] base;
    base = m_instret;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 3'd1, 4'b0011, 7'b0010011, 3'd0, rds[c], 1'b0, 1'b0, 1'b0);
      @(negedge clk); model_eval; e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL addi c%0d obs=%h exp=%h st=%0d", c, obs, e, fsm_state);
      end
      checks++;
      if (bus_if.rf_we !== (rds[c] != 0) || bus_if.alu_b_sel !== 1'b1 ||
          bus_if.instret !== base + c) begin
        errors++; $display("FAIL addi_fields c%0d rf_we=%b b_sel=%b instret=%0d want instret %0d",
                           c, bus_if.rf_we, bus_if.alu_b_sel, bus_if.instret, base + c);
      end
      advance;
    end
  endtask

  task automatic test_mul_ready;
    logic [43:0] e;
    int pc_low = 0;
    logic saw_wb = 1'b0;
    // Ready is raised in the start cycle (must be ignored) and after 4 waits.
    for (int c = 0; c < 7; c++) begin
      if (c < 6) drive(1'b1, 3'd0, 4'b0101, 7'b0110011, 3'd0, 5'd3, 1'b0, 1'b0, (c == 0 || c == 5));
      else       drive(1'b1, 3'd0, 4'b1101, 7'b1110011, 3'd1, 5'd4, 1'b0, 1'b0, 1'b1);
      @(negedge clk); model_eval; e = exp_q.pop_front();
      if (c < 6 && bus_if.pc_en === 1'b0) pc_low++;
      if (c == 5 && bus_if.rf_we === 1'b1 && bus_if.wb_sel === 2'b11) saw_wb = 1'b1;
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL mul_ready c%0d obs=%h exp=%h st=%0d", c, obs, e, fsm_state);
      end
      advance;
    end
    checks++;
    if (pc_low !== 5 || saw_wb !== 1'b1) begin
      errors++; $display("FAIL mul_ready_seq pc_en_low=%0d want 5 wb_seen=%b want 1", pc_low, saw_wb);
    end
  endtask

  task automatic test_mul_timeout;
    logic [43:0] e;
    logic [31:0] base;
    base = m_instret;
    for (int c = 0; c < 20; c++) begin
      if (c <= MUL_TIMEOUT) drive(1'b1, 3'd0, 4'b0110, 7'b0110011, 3'd0, 5'd9, 1'b0, 1'b0, 1'b0);
      else drive(1'b0, 3'd0, 4'd0, 7'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk); model_eval; e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL mul_timeout c%0d obs=%h exp=%h st=%0d", c, obs, e, fsm_state);
      end
      if (c == MUL_TIMEOUT + 1 || c == 19) begin
        checks++;
        if (bus_if.mul_abort !== 1'b1 || bus_if.instret !== base || bus_if.pc_en !== 1'b1) begin
          errors++; $display("FAIL mul_abort_sticky c%0d abort=%b instret=%0d want %0d pc_en=%b",
                             c, bus_if.mul_abort, bus_if.instret, base, bus_if.pc_en);
        end
      end
      advance;
    end
  endtask

  task automatic test_branch;
    logic [43:0] e;
    // {valid, itype, funct3, zero, lt}: bge taken, addi in shadow, bge not
    // taken, beq taken, shadow, blt not taken, bad funct3, bltu taken, bgeu
    logic [9:0] seq [10] = '{
      {1'b1, 3'd3, 3'd5, 1'b0, 1'b0, 1'b0}, {1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0},
      {1'b1, 3'd3, 3'd5, 1'b0, 1'b1, 1'b0}, {1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0},
      {1'b1, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0}, {1'b1, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0},
      {1'b1, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0}, {1'b1, 3'd3, 3'd6, 1'b0, 1'b1, 1'b0},
      {1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0}, {1'b1, 3'd3, 3'd7, 1'b1, 1'b1, 1'b0}};
    for (int c = 0; c < 10; c++) begin
      drive(seq[c][9], seq[c][8:6], 4'd0, 7'b1100011, seq[c][5:3], 5'd7,
            seq[c][2], seq[c][1], 1'b0);
      @(negedge clk); model_eval; e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL branch c%0d obs=%h exp=%h st=%0d", c, obs, e, fsm_state);
      end
      checks++;
      if (c == 0 && (bus_if.pc_sel !== 2'b01 || bus_if.fetch_flush !== 1'b1)) begin
        errors++; $display("FAIL bge_taken pc_sel=%b flush=%b want 01 1", bus_if.pc_sel, bus_if.fetch_flush);
      end else if (c == 1 && (bus_if.rf_we !== 1'b0 || bus_if.pc_en !== 1'b1)) begin
        errors++; $display("FAIL flush_shadow rf_we=%b pc_en=%b want 0 1", bus_if.rf_we, bus_if.pc_en);
      end else if (c == 6 && bus_if.illegal !== 1'b1) begin
        errors++; $display("FAIL bad_funct3 illegal=%b want 1", bus_if.illegal);
      end
      advance;
    end
  endtask

  task automatic test_jal;
    logic [43:0] e;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive(1'b1, 3'd4, 4'd0, 7'b1101111, 3'd0, 5'd1, 1'b0, 1'b0, 1'b0);
        2: drive(1'b1, 3'd1, 4'd0, 7'b1100111, 3'd0, 5'd2, 1'b0, 1'b0, 1'b0);
        4: drive(1'b1, 3'd6, 4'd0, 7'd0, 3'd0, 5'd2, 1'b0, 1'b0, 1'b0);
        default: drive(1'b1, 3'd2, 4'd0, 7'b0110111, 3'd0, 5'd8, 1'b0, 1'b0, 1'b0);
      endcase
      @(negedge clk); model_eval; e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL jal c%0d obs=%h exp=%h st=%0d", c, obs, e, fsm_state);
      end
      checks++;
      if (c == 0 && (bus_if.pc_sel !== 2'b10 || bus_if.rf_we !== 1'b1 || bus_if.wb_sel !== 2'b01)) begin
        errors++; $display("FAIL jal_fields pc_sel=%b rf_we=%b wb_sel=%b want 10 1 01",
                           bus_if.pc_sel, bus_if.rf_we, bus_if.wb_sel);
      end
      advance;
    end
  endtask

  task automatic test_reset_mid_mulw;
    logic [43:0] e;
    for (int c = 0; c < 7; c++) begin
      rst = (c == 4);
      if (c < 5) drive(1'b1, 3'd0, 4'b0111, 7'b0110011, 3'd0, 5'd3, 1'b0, 1'b0, 1'b0);
      else drive(1'b0, 3'd0, 4'd0, 7'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk); model_eval; e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL rst_mulw c%0d obs=%h exp=%h st=%0d", c, obs, e, fsm_state);
      end
      if (c == 5) begin
        checks++;
        if (bus_if.instret !== 32'd0 || bus_if.mul_abort !== 1'b0 || bus_if.pc_en !== 1'b0) begin
          errors++; $display("FAIL rst_mulw_clear instret=%0d abort=%b pc_en=%b want 0 0 0",
                             bus_if.instret, bus_if.mul_abort, bus_if.pc_en);
        end
      end
      advance;
    end
  endtask

  task automatic test_random;
    logic [43:0] e;
    logic [2:0] it;
    logic [3:0] ins;
    logic [6:0] opc;
    int r;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      r = $urandom_range(0, 9);
      it = (r < 8) ? 3'(r % 5) : 3'($urandom_range(5, 7));
      ins = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(5, 7)) : 4'($urandom_range(0, 15));
      opc = ($urandom_range(0, 1) == 0) ? 7'b1100111 : 7'($urandom_range(0, 127));
      drive(($urandom_range(0, 4) != 0), it, ins, opc, 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
      @(negedge clk); model_eval; e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++; $display("FAIL random c%0d obs=%h exp=%h st=%0d", c, obs, e, fsm_state);
      end
      advance;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 4'd0, 7'd0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    test_reset;
    test_addi;
    test_mul_ready;
    test_mul_timeout;
    test_branch;
    test_jal;
    test_reset_mid_mulw;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
